// File: rtl/uart_rx.sv
// UART receiver (8N1) with an MMIO-readable receive buffer and sticky error flags.
// Define UART_RX_FIFO_EN for a 4-entry FIFO; otherwise a single holding register is used.
module uart_rx #(
  parameter int DELAY_FRAMES    = 234,
  parameter int HALF_DELAY_WAIT = DELAY_FRAMES / 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        rx,
  input  logic [15:0] mmio_addr,
  input  logic        mmio_read,
  output logic [7:0]  mmio_rdata,
  output logic        rx_ready
);

  localparam logic [24:0] FULL_CNT    = 25'(DELAY_FRAMES);
  localparam logic [24:0] HALF_CNT    = 25'(HALF_DELAY_WAIT);
  localparam logic [15:0] ADDR_DATA   = 16'hf002;
  localparam logic [15:0] ADDR_STATUS = 16'hf003;

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HIGH} state_t;

  state_t      state_q, state_d;
  logic [24:0] cnt_q, cnt_d;
  logic [2:0]  bit_q, bit_d;
  logic [7:0]  shift_q, shift_d;
  logic        rx_meta, rx_sync;
  logic        cnt_half, cnt_full;
  logic        push, frame_err_set;
  logic        frame_err_q, overrun_q;
  logic        rd_data, rd_status;
  logic        do_push, do_pop, overrun_set;
  logic        full, empty;
  logic [7:0]  head;

  // NOTE: clocked state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_sync <= rx_meta;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
    end
  end

  assign cnt_half = (cnt_q + 25'd1) == HALF_CNT;
  assign cnt_full = (cnt_q + 25'd1) == FULL_CNT;

  always_comb begin
    // NOTE: every output gets a default first so no path leaves a value unassigned (no latches).
    state_d       = state_q;
    cnt_d         = cnt_q + 25'd1;
    bit_d         = bit_q;
    shift_d       = shift_q;
    push          = 1'b0;
    frame_err_set = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (!rx_sync) state_d = START;
      end
      START: begin
        if (cnt_half) begin
          cnt_d   = '0;
          bit_d   = '0;
          state_d = rx_sync ? IDLE : DATA;
        end
      end
      DATA: begin
        if (cnt_full) begin
          cnt_d          = '0;
          shift_d[bit_q] = rx_sync;
          bit_d          = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = STOP;
        end
      end
      STOP: begin
        if (cnt_full) begin
          cnt_d = '0;
          if (rx_sync) begin
            push    = 1'b1;
            state_d = IDLE;
          end else begin
            frame_err_set = 1'b1;
            state_d       = WAIT_HIGH;
          end
        end
      end
      WAIT_HIGH: begin
        cnt_d = '0;
        if (rx_sync) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign rd_data     = mmio_read && (mmio_addr == ADDR_DATA);
  assign rd_status   = mmio_read && (mmio_addr == ADDR_STATUS);
  assign do_pop      = rd_data && !empty;
  // A pop in the same cycle frees the slot, so a full buffer still accepts the push.
  assign do_push     = push && (!full || do_pop);
  assign overrun_set = push && full && !do_pop;
  assign rx_ready    = !empty;

`ifdef UART_RX_FIFO_EN
  logic [7:0] fifo_mem [4];
  logic [1:0] wr_ptr, rd_ptr;
  logic [2:0] count;

  assign full  = count == 3'd4;
  assign empty = count == 3'd0;
  assign head  = fifo_mem[rd_ptr];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 2'd1;
      if (do_pop)  rd_ptr <= rd_ptr + 2'd1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 3'd1;
        2'b01:   count <= count - 3'd1;
        default: count <= count;
      endcase
    end
  end

  // NOTE: storage is not reset; count gates every read so stale entries are never visible.
  always_ff @(posedge clock) begin
    if (do_push) fifo_mem[wr_ptr] <= shift_q;
  end
`else
  logic [7:0] hold_q;
  logic       valid_q;

  assign full  = valid_q;
  assign empty = !valid_q;
  assign head  = hold_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      hold_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      if (do_push) begin
        hold_q  <= shift_q;
        valid_q <= 1'b1;
      end else if (do_pop) begin
        valid_q <= 1'b0;
      end
    end
  end
`endif

  // Flags are sticky; a set arriving with a status-read clear wins.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      mmio_rdata  <= '0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      if (rd_data)
        mmio_rdata <= empty ? 8'h00 : head;
      else if (rd_status)
        mmio_rdata <= {5'b0, frame_err_q, overrun_q, rx_ready};
      frame_err_q <= frame_err_set || (frame_err_q && !rd_status);
      overrun_q   <= overrun_set   || (overrun_q   && !rd_status);
    end
  end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 The block SHALL have parameter DELAY_FRAMES, default 234, meaning clock cycles per bit (27 MHz / 115200 baud).
REQ-002 The block SHALL have parameter HALF_DELAY_WAIT, default DELAY_FRAMES/2, meaning cycles from the start-bit falling edge to the start-bit mid-point.
REQ-003 The block SHALL have port clock, input, 1 bit: the single system clock; all logic is rising-edge.
REQ-004 The block SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port rx, input, 1 bit: asynchronous serial line; idles high.
REQ-006 The block SHALL have port mmio_addr, input, 16 bits: MMIO read address.
REQ-007 The block SHALL have port mmio_read, input, 1 bit: one-cycle read strobe, qualified by mmio_addr.
REQ-008 The block SHALL have port mmio_rdata, output, 8 bits: registered read data.
REQ-009 The block SHALL have port rx_ready, output, 1 bit: high while at least one received byte is buffered.

Function
REQ-010 rx SHALL pass through a 2-flop synchronizer, idle value 1; all decisions use the synchronized value.
REQ-011 The state machine SHALL have states IDLE, START, DATA, STOP and WAIT_HIGH, with bit counter cnt (25 bits) and bit index (3 bits).
REQ-012 In IDLE, synchronized rx==0 SHALL move the machine to START with cnt=0.
REQ-013 In START, when cnt+1==HALF_DELAY_WAIT, rx==0 SHALL move the machine to DATA (cnt=0, bit=0) and rx==1 SHALL return it to IDLE as a glitch, with no flags changed.
REQ-014 In DATA, on each cnt+1==DELAY_FRAMES, the machine SHALL sample rx into shift[bit] (LSB first) and clear cnt; after bit 7 it SHALL go to STOP.
REQ-015 In STOP, on cnt+1==DELAY_FRAMES, rx==1 SHALL push the byte to the buffer and go to IDLE.
REQ-016 In STOP, on cnt+1==DELAY_FRAMES, rx==0 SHALL discard the byte, set sticky frame_err and go to WAIT_HIGH.
REQ-017 WAIT_HIGH SHALL remain until rx==1, then go to IDLE.
REQ-018 A mmio_read with mmio_addr==16'hf002 SHALL return the oldest byte on mmio_rdata the next cycle and pop it; when the buffer is empty it SHALL return 8'h00 with no state change.
REQ-019 A mmio_read with mmio_addr==16'hf003 SHALL return the status byte {5'b0, frame_err, overrun, rx_ready} the next cycle and then clear frame_err and overrun.
REQ-020 A flag set in the same cycle as a status-read clear SHALL remain set (set wins).
REQ-021 A push into a full buffer with no pop in the same cycle SHALL drop the new byte and set sticky overrun.
REQ-022 A push and a pop in the same cycle SHALL both complete, including when the buffer is full; overrun SHALL NOT be set in that case.
REQ-023 mmio_read at any other address SHALL leave mmio_rdata and all state unchanged.
REQ-024 Receive latency SHALL be: the byte becomes visible via rx_ready exactly 1 cycle after the stop-bit sample cycle.

Reset
REQ-025 While reset==0, the block SHALL force state=IDLE, cnt=0, bit=0, shift=0, synchronizer flops=1, buffer empty, rx_ready=0, mmio_rdata=8'h00, overrun=0 and frame_err=0.
REQ-026 Reset mid-frame SHALL abandon the frame; after release, reception SHALL restart only on a new falling edge.

Configuration
REQ-027 With UART_RX_FIFO_EN defined, the buffer SHALL be a 4-entry circular FIFO (2-bit read/write pointers, 3-bit count); pointers SHALL wrap 3->0 and full SHALL be count==4.
REQ-028 Without UART_RX_FIFO_EN, the buffer SHALL be a single holding register plus a valid bit; full SHALL equal valid.

Verification
REQ-029 Scenario: send 0xA5 at DELAY_FRAMES timing, then read 16'hf002 -> rx_ready rises 1 cycle after the stop sample; the read returns 0xA5; rx_ready returns to 0.
REQ-030 Scenario: drive rx low for 50 cycles, then high -> no byte, no flags, machine back in IDLE.
REQ-031 Scenario: send 0x3C with the stop bit driven low -> frame_err=1, rx_ready=0; a 16'hf003 read returns 0x04, and the next status read returns 0x00.
REQ-032 Scenario (FIFO build): send 0x01..0x05 with no reads -> 16'hf003 returns 0x03; four data reads return 0x01..0x04; a fifth read returns 0x00.
REQ-033 Scenario (no-FIFO build): send 0x11 then 0x22 unread -> a data read returns 0x11 and overrun=1.
REQ-034 Scenario: assert reset during DATA bit 4 of 0xFF, release, then send 0x5A -> only 0x5A is received, with no flags set.
